commit_trace_fifo: RTL and testbench

COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

---
 rtl/commit_trace_fifo.sv | 151 +++++++++++++++
 tb/tb_commit_trace_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: captures retiring-instruction trace records through a
// mode filter into a DEPTH-entry FIFO drained by a valid/ready consumer.
module commit_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       pc,
    input  logic [6:0]             opcode,
    input  logic [4:0]             RD,
    input  logic [WIDTH-1:0]       ALU_data_out,
    input  logic [WIDTH-1:0]       Mem_addr_out,
    input  logic [WIDTH-1:0]       RS2_data_out,
    input  logic [WIDTH-1:0]       dmu_out_data,
    input  logic                   tr_ready,
    output logic                   tr_valid,
    output logic [1:0]             tr_kind,
    output logic [4:0]             tr_rd,
    output logic [WIDTH-1:0]       tr_pc,
    output logic [WIDTH-1:0]       tr_addr,
    output logic [WIDTH-1:0]       tr_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [15:0]            overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] K_ALU   = 2'b00;
    localparam logic [1:0] K_LOAD  = 2'b01;
    localparam logic [1:0] K_STORE = 2'b10;
    localparam logic [1:0] K_OTHER = 2'b11;

    typedef struct packed {
        logic [1:0]       kind;
        logic [4:0]       rd;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        new_entry;
    entry_t        head;
    logic [1:0]    kind;
    logic          pass;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Classify the retiring instruction by opcode.
    always_comb begin
        kind = K_OTHER;
        case (opcode)
            7'b0000011: kind = K_LOAD;
            7'b0100011: kind = K_STORE;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: kind = K_ALU;
            default:    kind = K_OTHER;
        endcase
    end

    // Assemble the record; fields that do not apply to a kind are zeroed.
    always_comb begin
        new_entry      = '0;
        new_entry.kind = kind;
        new_entry.pc   = pc;
        case (kind)
            K_LOAD: begin
                new_entry.data = dmu_out_data;
                new_entry.addr = Mem_addr_out;
                new_entry.rd   = RD;
            end
            K_STORE: begin
                new_entry.data = RS2_data_out;
                new_entry.addr = Mem_addr_out;
            end
            K_ALU: begin
                new_entry.data = ALU_data_out;
                new_entry.rd   = RD;
            end
            default: new_entry.data = ALU_data_out;
        endcase
    end

    // Capture filter, evaluated with this cycle's mode.
    always_comb begin
        pass = 1'b0;
        case (mode)
            2'b00:   pass = 1'b1;
            2'b01:   pass = (kind == K_LOAD) || (kind == K_STORE);
            2'b10:   pass = ((kind == K_ALU) || (kind == K_LOAD)) && (RD != 5'd0);
            default: pass = 1'b0;
        endcase
    end

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign tr_valid = !empty;
    assign push_req = cap_en && pass;
    assign do_pop   = tr_valid && tr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    // Storage array; no reset needed, occupancy tracking guards stale slots.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[wr_ptr] <= new_entry;
    end

    // Pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop && (overflow_cnt != 16'hFFFF))
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    // Head is forced to zero while empty so stale slots never leak out.
    assign head    = empty ? '0 : mem[rd_ptr];
    assign tr_kind = head.kind;
    assign tr_rd   = head.rd;
    assign tr_pc   = head.pc;
    assign tr_addr = head.addr;
    assign tr_data = head.data;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: stimulus queues expected records,
// a negedge monitor pops and compares every accepted head entry.
module tb_commit_trace_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cap_en = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] pc = '0;
    logic [6:0]       opcode = '0;
    logic [4:0]       RD = '0;
    logic [WIDTH-1:0] ALU_data_out = '0;
    logic [WIDTH-1:0] Mem_addr_out = '0;
    logic [WIDTH-1:0] RS2_data_out = '0;
    logic [WIDTH-1:0] dmu_out_data = '0;
    logic             tr_ready = 1'b0;
    logic             tr_valid;
    logic [1:0]       tr_kind;
    logic [4:0]       tr_rd;
    logic [WIDTH-1:0] tr_pc;
    logic [WIDTH-1:0] tr_addr;
    logic [WIDTH-1:0] tr_data;
    logic [$clog2(DEPTH):0] count;
    logic             full;
    logic             empty;
    logic [15:0]      overflow_cnt;

    commit_trace_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .mode(mode), .pc(pc),
        .opcode(opcode), .RD(RD), .ALU_data_out(ALU_data_out),
        .Mem_addr_out(Mem_addr_out), .RS2_data_out(RS2_data_out),
        .dmu_out_data(dmu_out_data), .tr_ready(tr_ready), .tr_valid(tr_valid),
        .tr_kind(tr_kind), .tr_rd(tr_rd), .tr_pc(tr_pc), .tr_addr(tr_addr),
        .tr_data(tr_data), .count(count), .full(full), .empty(empty),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_pop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [4:0] r, input logic [31:0] p,
                            input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.rd = r; e.pc = p; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic set_fields(input logic [6:0] opc, input logic [4:0] r, input logic [31:0] p,
                              input logic [31:0] alu, input logic [31:0] ad,
                              input logic [31:0] rs2, input logic [31:0] dmu);
        opcode = opc; RD = r; pc = p; ALU_data_out = alu;
        Mem_addr_out = ad; RS2_data_out = rs2; dmu_out_data = dmu;
    endtask

    task automatic capture(input logic [6:0] opc, input logic [4:0] r, input logic [31:0] p,
                           input logic [31:0] alu, input logic [31:0] ad,
                           input logic [31:0] rs2, input logic [31:0] dmu);
        set_fields(opc, r, p, alu, ad, rs2, dmu);
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
    endtask

    task automatic drain(input int n);
        tr_ready = 1'b1;
        repeat (n) tick();
        tr_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_valid"}, 64'(tr_valid), 64'd0);
        chk({tag, "_fields"}, 64'(tr_kind) | 64'(tr_rd) | 64'(tr_pc) | 64'(tr_addr) | 64'(tr_data), 64'd0);
    endtask

    // Monitor: every accepted head entry must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && tr_valid && tr_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: DUT presented pc=0x%0h, scoreboard held nothing", tr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("pop%0d_kind", n_pop), 64'(tr_kind), 64'(mon_e.kind));
                chk($sformatf("pop%0d_rd", n_pop), 64'(tr_rd), 64'(mon_e.rd));
                chk($sformatf("pop%0d_pc", n_pop), 64'(tr_pc), 64'(mon_e.pc));
                chk($sformatf("pop%0d_addr", n_pop), 64'(tr_addr), 64'(mon_e.addr));
                chk($sformatf("pop%0d_data", n_pop), 64'(tr_data), 64'(mon_e.data));
            end
            n_pop++;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_ovf", 64'(overflow_cnt), 64'd0);

        // Mode 00: single load, visible one cycle later, no same-cycle bypass.
        mode = 2'b00;
        set_fields(OP_LOAD, 5'd5, 32'h100, 32'h77, 32'h2000, 32'h99, 32'hDEADBEEF);
        cap_en = 1'b1;
        #1;
        chk("load_no_bypass", 64'(tr_valid), 64'd0);
        push_exp(2'b01, 5'd5, 32'h100, 32'h2000, 32'hDEADBEEF);
        tick();
        cap_en = 1'b0;
        chk("load_valid", 64'(tr_valid), 64'd1);
        chk("load_kind", 64'(tr_kind), 64'd1);
        chk("load_addr", 64'(tr_addr), 64'h2000);
        chk("load_data", 64'(tr_data), 64'hDEADBEEF);
        chk("load_rd", 64'(tr_rd), 64'd5);
        tick();
        chk("load_held", 64'(tr_pc), 64'h100);
        drain(1);
        chk_idle("load_drained");

        // Mode 00: ALU op and an unclassified opcode.
        push_exp(2'b00, 5'd4, 32'h104, 32'h0, 32'h1234);
        capture(OP_REG, 5'd4, 32'h104, 32'h1234, 32'h5555, 32'h66, 32'h77);
        push_exp(2'b11, 5'd0, 32'h108, 32'h0, 32'hABCD);
        capture(OP_SYS, 5'd9, 32'h108, 32'hABCD, 32'h5555, 32'h66, 32'h77);
        chk("m0_count", 64'(count), 64'd2);
        drain(2);

        // Mode 01: ALU filtered, store queued.
        mode = 2'b01;
        capture(OP_REG, 5'd1, 32'h200, 32'h11, 32'h3000, 32'h22, 32'h33);
        push_exp(2'b10, 5'd0, 32'h204, 32'h3000, 32'h55);
        capture(OP_STORE, 5'd7, 32'h204, 32'h11, 32'h3000, 32'h55, 32'h33);
        chk("m1_count", 64'(count), 64'd1);
        chk("m1_kind", 64'(tr_kind), 64'd2);
        chk("m1_data", 64'(tr_data), 64'h55);
        drain(1);

        // Mode 10: RD=0 and stores filtered, RD=3 kept.
        mode = 2'b10;
        capture(OP_IMM, 5'd0, 32'h300, 32'h31, 32'h0, 32'h0, 32'h0);
        push_exp(2'b00, 5'd3, 32'h304, 32'h0, 32'h33);
        capture(OP_IMM, 5'd3, 32'h304, 32'h33, 32'h0, 32'h0, 32'h0);
        capture(OP_STORE, 5'd6, 32'h308, 32'h0, 32'h4000, 32'h44, 32'h0);
        chk("m2_count", 64'(count), 64'd1);
        chk("m2_rd", 64'(tr_rd), 64'd3);
        drain(1);

        // Mode 11: nothing passes.
        mode = 2'b11;
        capture(OP_LOAD, 5'd2, 32'h400, 32'h0, 32'h5000, 32'h0, 32'h9);
        chk_idle("m3");

        // Fill past capacity with pointers starting mid-array: 4 drops.
        mode = 2'b00;
        for (int i = 0; i < 20; i++) begin
            if (i < DEPTH) push_exp(2'b00, 5'(i + 1), 32'(i), 32'h0, 32'(i * 3 + 1));
            capture(OP_REG, 5'(i + 1), 32'(i), 32'(i * 3 + 1), 32'hFFFF, 32'h0, 32'h0);
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_ovf", 64'(overflow_cnt), 64'd4);
        chk("fill_head_pc", 64'(tr_pc), 64'd0);
        mode = 2'b11;
        repeat (2) tick();
        chk("fill_mode_change_count", 64'(count), 64'd16);

        // Full with push and pop together: count holds, no drop, new entry at tail.
        mode = 2'b00;
        tr_ready = 1'b1;
        push_exp(2'b00, 5'd30, 32'h99, 32'h0, 32'h999);
        capture(OP_REG, 5'd30, 32'h99, 32'h999, 32'h0, 32'h0, 32'h0);
        chk("pp_count", 64'(count), 64'd16);
        chk("pp_full", 64'(full), 64'd1);
        chk("pp_ovf", 64'(overflow_cnt), 64'd4);
        drain(16);
        chk_idle("pp_drained");

        // Reset with 7 queued and a push pending discards everything.
        for (int i = 0; i < 7; i++)
            capture(OP_REG, 5'd2, 32'(32'h600 + i), 32'h5, 32'h0, 32'h0, 32'h0);
        chk("pre_rst_count", 64'(count), 64'd7);
        set_fields(OP_LOAD, 5'd8, 32'h700, 32'h0, 32'h8000, 32'h0, 32'h88);
        cap_en = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        cap_en = 1'b0;
        chk_idle("rst7");
        chk("rst7_ovf", 64'(overflow_cnt), 64'd0);

        // Operation resumes after reset.
        push_exp(2'b01, 5'd8, 32'h704, 32'h8004, 32'h89);
        capture(OP_LOAD, 5'd8, 32'h704, 32'h0, 32'h8004, 32'h0, 32'h89);
        chk("post_rst_count", 64'(count), 64'd1);
        drain(1);
        chk_idle("final");
        chk("sb_left", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
